// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential right shifter: FSM encoding, shift modes
// and default sizes.
package shifter_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SHIFT_SRL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

endpackage

// File: rtl/shifter_right_seq_rshift_stage.sv
// One stage of the logarithmic right shifter, built from mux2to1 cells: a 5:1
// distance select (16/8/4/2/1) followed by a per-bit pass/shift select.
module mux2to1 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module rshift_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] work,
    input  logic [2:0]       stage,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);
    logic [4:0][WIDTH-1:0] cand;
    logic [WIDTH-1:0]      m01, m23, m03, dist_sel;

    // cand[k] is work shifted right by 2^k with the requested fill bit
    for (genvar k = 0; k < 5; k++) begin : g_cand
        localparam int D = 1 << k;
        assign cand[k] = {{D{fill}}, work[WIDTH-1:D]};
    end

    mux2to1 #(.W(WIDTH)) u_m01 (.a(cand[0]), .b(cand[1]), .sel(stage[0]), .y(m01));
    mux2to1 #(.W(WIDTH)) u_m23 (.a(cand[2]), .b(cand[3]), .sel(stage[0]), .y(m23));
    mux2to1 #(.W(WIDTH)) u_m03 (.a(m01),     .b(m23),     .sel(stage[1]), .y(m03));
    mux2to1 #(.W(WIDTH)) u_m04 (.a(m03),     .b(cand[4]), .sel(stage[2]), .y(dist_sel));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2to1 #(.W(1)) u_pass (.a(work[i]), .b(dist_sel[i]), .sel(en), .y(shifted[i]));
    end

endmodule

// File: rtl/shifter_right_seq.sv
// Multi-cycle SRL/SRA: one logarithmic stage per clock (16,8,4,2,1) through a
// shared stage datapath, with a start/busy/done handshake.
module shifter_right_seq #(
    parameter int WIDTH   = shifter_pkg::DEF_WIDTH,
    parameter int SHAMT_W = shifter_pkg::DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);
    import shifter_pkg::*;

    localparam int STG_W = $clog2(SHAMT_W);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work, shifted;
    logic [SHAMT_W-1:0] amt;
    logic               mode;
    logic [STG_W-1:0]   stage;
    logic               en, fill;
    logic               unused_hi;

    // Upper shift-amount bits are architecturally ignored.
    assign unused_hi = ^dataB[WIDTH-1:SHAMT_W];

    assign en   = amt[stage];
    assign fill = (mode == SHIFT_SRA) ? work[WIDTH-1] : 1'b0;

    rshift_stage #(.WIDTH(WIDTH)) u_stage (
        .work    (work),
        .stage   (stage),
        .en      (en),
        .fill    (fill),
        .shifted (shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (stage == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work    <= '0;
            amt     <= '0;
            mode    <= 1'b0;
            stage   <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    work  <= dataA;
                    amt   <= dataB[SHAMT_W-1:0];
                    mode  <= Signal;
                    stage <= STG_W'(SHAMT_W - 1);
                end
                SHIFT: begin
                    work <= shifted;
                    if (stage == '0) dataOut <= shifted;
                    else             stage   <= stage - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shifter_right_seq.md
Name: shifter_right_seq

Overview:
- Multi-cycle 32-bit right shifter for the pipelined CPU's execute stage; it is the right-shift counterpart of the combinational left barrel shifter.
- Implements SRL and SRA as a logarithmic shifter: stage distances 16, 8, 4, 2, 1, one stage evaluated per clock, sharing one stage datapath.
- Start/busy/done handshake to the ALU-control FSM; the result is held until the next accepted start.

Parameters:
- WIDTH, 32, data width; power of two.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dataA  input  32  operand to shift.
- dataB  input  32  shift amount; only dataB[4:0] used, dataB[31:5] ignored.
- Signal  input  1  0 = SRL (zero fill), 1 = SRA (sign fill).
- dataOut  output  32  result register.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when dataOut is valid.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-high. While reset is high: state=IDLE, dataOut=0, busy=0, done=0, internal data/amount/mode/stage registers=0.
- States:
  - IDLE: start=1 latches dataA into the work register, dataB[4:0] into amt, Signal into mode, and sets stage=4; next state SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle, if amt[stage]=1, work <= work >> 2^stage, with vacated MSBs filled by 0 (mode=0) or work[31] (mode=1); otherwise work unchanged. Then stage decrements. On stage=0, dataOut <= shifted work and next state is DONE.
  - DONE: done=1 for this single cycle; next state IDLE unconditionally.
- busy=1 in SHIFT and DONE; busy=0 in IDLE.
- Latency:
  - start sampled at edge T; stages execute at edges T+1..T+5; done=1 and dataOut valid in the cycle following edge T+5.
  - Fixed 5 stage cycles regardless of amt; no early exit.
  - Back-to-back issue rate: one operation per 7 cycles.
- Handshake rules:
  - start is ignored while busy=1, including during the DONE cycle; latched operands are unaffected by input changes after acceptance.
  - dataOut holds its value from DONE until the next operation's DONE; it is not cleared at start.
- Arithmetic rules:
  - amt=0 gives dataOut=dataA.
  - amt=31 SRA gives all copies of dataA[31]; amt=31 SRL gives {31'b0, dataA[31]}.
  - Sign fill uses the current work[31]; this equals the original sign because SRA never changes bit 31.
- Reset mid-operation: immediate abort; all outputs 0; no done pulse. The first start after reset deassertion is accepted normally.

Decomposition:
- Shared package (shifter_pkg):
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - mode constants SHIFT_SRL=1'b0, SHIFT_SRA=1'b1;
  - WIDTH/SHAMT_W defaults.
- One combinational sub-module, rshift_stage: inputs work[31:0], stage[2:0], en, fill; output shifted[31:0].
  - Built from the team's existing mux2to1 cells: a 5:1 distance select followed by a pass/shift mux per bit.
- Top level holds the FSM, stage counter and registers.

Test Plan:
- SRL dataA=0x80000000, dataB=31 -> dataOut=0x00000001; done exactly 6 cycles after the start edge; busy high 6 cycles.
- SRA dataA=0x80000000, dataB=4 -> 0xF8000000. SRA dataA=0x7FFFFFF0, dataB=4 -> 0x07FFFFFF.
- SRL dataA=0xDEADBEEF, dataB=0 -> 0xDEADBEEF with the same 6-cycle latency. dataB=0x00000024 on dataA=0x12345678 (upper bits ignored, amt=4) -> 0x01234567.
- Start while busy:
  - accept 0xF0000000 SRL 8, then pulse start with 0xFFFFFFFF SRA 1 during SHIFT and DONE;
  - required: dataOut=0x00F00000, a single done pulse, and the second request dropped.
- Reset abort: assert reset during the third SHIFT cycle -> dataOut/busy/done=0 within the same cycle with no clock edge. After release, 0x00000100 SRL 8 -> 0x00000001.
